// File: rtl/dma_multichan.sv
// Multi-channel byte-mover DMA: per-channel SRC/DST/LEN/CTRL, round-robin arbitration, one byte per beat.
// Optional feature: define DMA_FIXED_DST_EN to honour CTRL bit 2 (fixed destination address).
module dma_multichan #(
  parameter int NCH = 2,
  parameter int AW  = 8,
  parameter int LW  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic [1:0]                       cfg_ch,
  input  logic [1:0]                       cfg_sel,
  input  logic [((AW > LW) ? AW : LW)-1:0] cfg_wdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [AW-1:0]                    mem_addr,
  output logic [7:0]                       mem_wdata,
  input  logic                             mem_gnt,
  input  logic                             mem_rvalid,
  input  logic [7:0]                       mem_rdata,
  output logic [NCH-1:0]                   busy,
  output logic [NCH-1:0]                   done,
  output logic                             irq
);

  typedef enum logic [2:0] {IDLE, ARB, RD, RWAIT, WR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q [4];
  logic [AW-1:0] dst_q [4];
  logic [LW-1:0] len_q [4];
`ifdef DMA_FIXED_DST_EN
  logic [3:0]    fix_q;
`endif
  logic [3:0]    busy_q, busy_d;
  logic [3:0]    done_q, done_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    rr_q, rr_d;
  logic [7:0]    data_q;
  logic          data_ld;
  logic          wr_ok, ctrl_wr, inflight, beat_done;
  logic [1:0]    pick;
  logic          pick_ok;
  logic [2:0]    sum;

  assign wr_ok     = cfg_we && ({1'b0, cfg_ch} < 3'(NCH));
  assign ctrl_wr   = wr_ok && (cfg_sel == 2'd3);
  assign inflight  = (state_q == RD) || (state_q == RWAIT) || (state_q == WR);
  assign beat_done = (state_q == WR) && mem_gnt;

  assign busy = busy_q[NCH-1:0];
  assign done = done_q[NCH-1:0];
  assign irq  = |done_q;

  // A channel still owning the current beat (even after abort) refuses cfg writes.
  function automatic logic is_locked(input logic [1:0] c);
    return busy_q[c] | (inflight && (cur_q == c));
  endfunction

  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ctrl_wr && (cfg_ch == 2'(i))) begin
        if (cfg_wdata[1]) begin
          busy_d[2'(i)] = 1'b0;
        end else if (cfg_wdata[0]) begin
          if (!is_locked(2'(i))) begin
            if (len_q[2'(i)] == '0) begin
              done_d[2'(i)] = 1'b1;
            end else begin
              busy_d[2'(i)] = 1'b1;
              done_d[2'(i)] = 1'b0;
            end
          end
        end else begin
          done_d[2'(i)] = 1'b0;
        end
      end
      if (beat_done && (cur_q == 2'(i)) && busy_q[2'(i)] && (len_q[2'(i)] == LW'(1))) begin
        busy_d[2'(i)] = 1'b0;
        if (!(ctrl_wr && (cfg_ch == 2'(i)) && cfg_wdata[1])) done_d[2'(i)] = 1'b1;
      end
    end
  end

  // Round-robin search starting at rr_q (the channel after the last one served).
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      if (sum >= 3'(NCH)) sum = sum - 3'(NCH);
      if (!pick_ok && busy_q[sum[1:0]]) begin
        pick    = sum[1:0];
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    data_ld   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: if (|busy_q) state_d = ARB;
      ARB: begin
        if (pick_ok) begin
          state_d = RD;
          cur_d   = pick;
          rr_d    = (pick == 2'(NCH - 1)) ? 2'd0 : pick + 2'd1;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (!busy_q[cur_q]) begin
          state_d = (|busy_d) ? ARB : IDLE;
        end else begin
          mem_req  = 1'b1;
          mem_addr = src_q[cur_q];
          if (mem_gnt) state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (!busy_q[cur_q]) begin
          state_d = (|busy_d) ? ARB : IDLE;
        end else if (mem_rvalid) begin
          data_ld = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q[cur_q];
        mem_wdata = data_q;
        if (mem_gnt) state_d = (|busy_d) ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rr_q    <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      data_q  <= '0;
`ifdef DMA_FIXED_DST_EN
      fix_q   <= '0;
`endif
      for (int unsigned i = 0; i < 4; i++) begin
        src_q[2'(i)] <= '0;
        dst_q[2'(i)] <= '0;
        len_q[2'(i)] <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (data_ld) data_q <= mem_rdata;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wr_ok && (cfg_ch == 2'(i)) && !is_locked(2'(i))) begin
          case (cfg_sel)
            2'd0: src_q[2'(i)] <= cfg_wdata[AW-1:0];
            2'd1: dst_q[2'(i)] <= cfg_wdata[AW-1:0];
            2'd2: len_q[2'(i)] <= cfg_wdata[LW-1:0];
`ifdef DMA_FIXED_DST_EN
            2'd3: if (cfg_wdata[0] && !cfg_wdata[1]) fix_q[2'(i)] <= cfg_wdata[2];
`endif
            default: ;
          endcase
        end
        if (beat_done && (cur_q == 2'(i))) begin
          src_q[2'(i)] <= src_q[2'(i)] + AW'(1);
`ifdef DMA_FIXED_DST_EN
          if (!fix_q[2'(i)]) dst_q[2'(i)] <= dst_q[2'(i)] + AW'(1);
`else
          dst_q[2'(i)] <= dst_q[2'(i)] + AW'(1);
`endif
          len_q[2'(i)] <= len_q[2'(i)] - LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_multichan.sv
// Directed bench for dma_multichan: memory model plus an access-order scoreboard.
module tb_dma_multichan;

  localparam logic [1:0] R_SRC = 2'd0, R_DST = 2'd1, R_LEN = 2'd2, R_CTRL = 2'd3;
`ifdef DMA_FIXED_DST_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_wdata = '0;
  logic       mem_req, mem_we, mem_gnt, mem_rvalid, irq;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] busy, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;
  acc_t exp_q[$];

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic       pend = 1'b0;
  logic [7:0] pdata = '0;
  bit         hold = 1'b0, drop_pend = 1'b0, gnt_en = 1'b1, init_req = 1'b1;

  dma_multichan #(.NCH(2), .AW(8), .LW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  assign mem_gnt    = gnt_en;
  assign mem_rvalid = pend && !hold;
  assign mem_rdata  = pdata;

  // Memory: read data returns one cycle after the read grant unless held back.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 13 + 7);
    end
    if (!rst_n || drop_pend) begin
      pend <= 1'b0;
    end else begin
      if (mem_rvalid) pend <= 1'b0;
      if (mem_req && mem_gnt && !mem_we) begin
        pend  <= 1'b1;
        pdata <= mem[mem_addr];
      end
      if (mem_req && mem_gnt && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin : monitor
    acc_t obs, e;
    if (rst_n && mem_req && mem_gnt) begin
      obs = {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)};
      vectors++;
      if (exp_q.size() == 0) begin
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_access observed=%h expected=none", obs);
        end
      end else begin
        e = exp_q.pop_front();
        if (!e.we) e.data = 8'h00;
        assert (obs === e) else begin
          miscompares++;
          $error("FAIL access observed=%h expected=%h", obs, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input logic [1:0] ch, input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    cfg(ch, R_SRC, s);
    cfg(ch, R_DST, d);
    cfg(ch, R_LEN, n);
  endtask

  function automatic void push_beat(input logic [7:0] s, input logic [7:0] d);
    exp_q.push_back({1'b0, s, exp_mem[s]});
    exp_q.push_back({1'b1, d, exp_mem[s]});
    exp_mem[d] = exp_mem[s];
  endfunction

  task automatic wait_drain(input string tag, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy != 2'b00) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_q(input string tag, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 13 + 7);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_irq", {done, irq}, 32'd0);
    check("rst_mem_outs", {mem_req, mem_we, mem_addr, mem_wdata}, 32'd0);
    init_req = 1'b0;
    rst_n = 1'b1;

    // Single channel, three bytes
    setup(2'd0, 8'h10, 8'h80, 8'd3);
    for (int b = 0; b < 3; b++) push_beat(8'(8'h10 + b), 8'(8'h80 + b));
    cfg(2'd0, R_CTRL, 8'h01);
    wait_drain("xfer3_drain", 200);
    check("xfer3_done", 32'(done), 32'd1);
    check("xfer3_irq", 32'(irq), 32'd1);
    cfg(2'd0, R_CTRL, 8'h00);
    check("ack_done_irq", {done, irq}, 32'd0);

    // Two channels interleave byte by byte; cfg writes to a busy channel are dropped
    do_reset();
    setup(2'd0, 8'h20, 8'h90, 8'd2);
    setup(2'd1, 8'h30, 8'hA0, 8'd2);
    push_beat(8'h20, 8'h90);
    push_beat(8'h30, 8'hA0);
    push_beat(8'h21, 8'h91);
    push_beat(8'h31, 8'hA1);
    cfg(2'd0, R_CTRL, 8'h01);
    cfg(2'd1, R_CTRL, 8'h01);
    cfg(2'd0, R_SRC, 8'hEE);
    wait_drain("rr_drain", 300);
    check("rr_done", 32'(done), 32'd3);

    // Source wrap, with grant withheld to show the request holding
    do_reset();
    setup(2'd0, 8'hFF, 8'h50, 8'd2);
    push_beat(8'hFF, 8'h50);
    push_beat(8'h00, 8'h51);
    gnt_en = 1'b0;
    cfg(2'd0, R_CTRL, 8'h01);
    repeat (3) @(negedge clk);
    check("hold_req_a", {mem_req, mem_we, mem_addr}, {22'd0, 1'b1, 1'b0, 8'hFF});
    @(negedge clk);
    check("hold_req_b", {mem_req, mem_we, mem_addr}, {22'd0, 1'b1, 1'b0, 8'hFF});
    gnt_en = 1'b1;
    wait_drain("wrap_drain", 200);
    check("wrap_done", 32'(done), 32'd1);

    // Out-of-range channel ignored; LEN=0 start completes with no access
    do_reset();
    cfg(2'd2, R_CTRL, 8'h01);
    check("bad_ch_ignored", {busy, done}, 32'd0);
    cfg(2'd1, R_SRC, 8'h33);
    cfg(2'd1, R_CTRL, 8'h01);
    check("len0_done", 32'(done), 32'd2);
    check("len0_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("len0_no_req", 32'(cnt), 32'd0);

    // Abort ch0 while it waits for read data; ch1 carries on
    do_reset();
    setup(2'd0, 8'h60, 8'hB0, 8'd5);
    setup(2'd1, 8'h70, 8'hC0, 8'd2);
    hold = 1'b1;
    exp_q.push_back({1'b0, 8'h60, exp_mem[8'h60]});
    cfg(2'd0, R_CTRL, 8'h01);
    cfg(2'd1, R_CTRL, 8'h01);
    wait_q("abort_rd_seen", 50);
    repeat (2) @(negedge clk);
    push_beat(8'h70, 8'hC0);
    push_beat(8'h71, 8'hC1);
    cfg(2'd0, R_CTRL, 8'h02);
    check("abort_busy0", 32'(busy[0]), 32'd0);
    drop_pend = 1'b1;
    @(negedge clk);
    drop_pend = 1'b0;
    hold = 1'b0;
    wait_drain("abort_drain", 200);
    check("abort_done", 32'(done), 32'd2);

    // CTRL bit 2: fixed destination when the feature is built in, ignored otherwise
    do_reset();
    setup(2'd0, 8'h05, 8'h40, 8'd3);
    for (int b = 0; b < 3; b++) push_beat(8'(8'h05 + b), FIX ? 8'h40 : 8'(8'h40 + b));
    cfg(2'd0, R_CTRL, 8'h05);
    wait_drain("fix_drain", 200);
    check("fix_done", 32'(done), 32'd1);

    // Reset in the middle of a transfer
    setup(2'd1, 8'h08, 8'hD0, 8'd5);
    hold = 1'b1;
    exp_q.push_back({1'b0, 8'h08, exp_mem[8'h08]});
    cfg(2'd1, R_CTRL, 8'h01);
    wait_q("midrst_rd_seen", 50);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_flags", {busy, done, irq}, 32'd0);
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check("midrst_no_req", 32'(cnt), 32'd0);
    cfg(2'd1, R_CTRL, 8'h01);
    check("midrst_len_cleared", {busy, done}, 32'd2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
